mult_accumulator: RTL and testbench
===================================

// Module: mult_accumulator
// PURPOSE
//  Stage directly downstream of the 4-lane multiply channel. Pops one product group (4 x signed
//  16-bit) per cycle from the per-lane mult FIFOs, reduces it through a registered adder tree and
//  accumulates ROW_LEN groups into one dot-product partial sum, handed off on a valid/ready port.
// PARAMETERS
//  LANES   4   product lanes, one mult FIFO each
//  PROD_W  16  signed product width per lane (mult bus = LANES*PROD_W)
//  ACC_W   32  signed accumulator / result width
//  LEN_W   16  width of row_len and the group counters
// PORTS
//  clk             in   1              clock, all logic on rising edge
//  rst             in   1              synchronous, active-high reset
//  start           in   1              pulse: begin a row; honoured only in IDLE
//  row_len         in   LEN_W          groups in the row, sampled with start
//  mult            in   LANES*PROD_W   lane i = mult[i*PROD_W +: PROD_W], two's complement
//  mult_fifo_empty in   LANES          per-lane FIFO empty flag
//  mult_fifo_read  out  LANES          per-lane pop strobe
//  sum             out  ACC_W          accumulated row result
//  sum_valid       out  1              sum holds a completed row
//  sum_ready       in   1              consumer accepts sum
//  busy            out  1              high in any state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; mult_fifo_read=0, sum=0, sum_valid=0, busy=0; counters, acc, pipe valid=0.
//  - mult FIFOs are first-word-fall-through: mult lane valid whenever its empty=0; pop = consume.
//  - Lane-lockstep pop: mult_fifo_read = {LANES{fire}}, fire = (state==ACCUM) & ~|mult_fifo_empty
//    & (issued < len). Never pop a subset of lanes. mult_fifo_read is combinational from state/flags.
//  - States: IDLE -> ACCUM on start (len<=row_len, issued=0, done=0, acc=0).
//    ACCUM -> DRAIN when done==len (all accepted groups accumulated). DRAIN -> IDLE on sum_ready.
//  - Stage 1 (registered): s1_sum = sign-extended sum of all lanes (PROD_W+2 bits), s1_v = fire.
//  - Stage 2: on s1_v, acc <= acc + sext(s1_sum) mod 2^ACC_W (wraps, no saturation); done++.
//  - Latency: last pop at cycle t -> acc updated t+2 -> sum_valid=1 at t+3 (state DRAIN).
//  - sum = acc in DRAIN; sum, sum_valid stable until sum_ready. sum_valid=0 outside DRAIN.
//  - row_len==0: ACCUM sees done==len immediately; sum_valid=1 with sum=0 two cycles after start.
//  - No overrun: issued counter stops pops at len even if FIFOs stay non-empty.
//  - Any lane empty: fire=0 that cycle, no partial pop, pipeline bubbles; accumulation unaffected.
//  - start while busy (incl. same cycle as sum_ready in DRAIN) is ignored; caller retries in IDLE.
//  - rst mid-row: everything returns to reset values next edge; unpopped FIFO data left untouched.
// STRUCTURE
//  - sparse_pkg: LANES, PROD_W, ACC_W, LEN_W defaults and state enum localparams
//    (ST_IDLE, ST_ACCUM, ST_DRAIN).
//  - Sub-module lane_adder_tree (LANES, PROD_W): combinational signed reduction of the mult bus;
//    stage-1 register and FSM/accumulator stay in mult_accumulator.
// TESTING
//  1 Reset: rst high 2 cycles with FIFOs non-empty -> mult_fifo_read=0, sum_valid=0, sum=0, busy=0.
//  2 Single group: row_len=1, lanes {0,36,-112,75} (lane3..0) -> one pop, sum=-1 (0xFFFFFFFF), sum_valid.
//  3 Two groups: {0,36,-112,75} then {0,360,-192,500}, row_len=2 -> exactly 2 pops, sum=667.
//  4 Stall: lane 2 empty for 3 cycles mid-row, row_len=4, every group {1,1,1,1} -> no read
//    while empty, all lanes pop together, sum=16.
//  5 Backpressure/overrun: row_len=2, FIFOs stay non-empty, sum_ready=0 for 10 cycles -> exactly 2
//    pops, sum held at its value, start ignored; sum_ready=1 -> IDLE next cycle.
//  6 Edge: row_len=0 -> sum=0 valid after 2 cycles, zero pops; acc wrap: 0x7FFFFFFF + 1 -> 0x80000000.

Source files
------------

// File: rtl/sparse_pkg.sv
// rtl/sparse_pkg.sv - shared widths and state encoding for the mult accumulator
//
// Holds the default geometry of the 4-lane multiply channel and the
// accumulator FSM state encoding. No ports.
package sparse_pkg;

    localparam int LANES_DEF  = 4;   // product lanes, one mult FIFO each
    localparam int PROD_W_DEF = 16;  // signed product width per lane
    localparam int ACC_W_DEF  = 32;  // signed accumulator / result width
    localparam int LEN_W_DEF  = 16;  // row length and group counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width that holds the sum of all lanes without overflow.
    function automatic int tree_w(input int lanes, input int prod_w);
        return prod_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// rtl/lane_adder_tree.sv - combinational signed reduction of one product group
//
// Ports:
//   mult_i  in   LANES*PROD_W  lane i = mult_i[i*PROD_W +: PROD_W], two's complement
//   sum_o   out  SUM_W         two's complement sum of all lanes
module lane_adder_tree #(
    parameter int LANES  = 4,
    parameter int PROD_W = 16,
    parameter int SUM_W  = PROD_W + $clog2(LANES)
) (
    input  logic [LANES*PROD_W-1:0] mult_i,
    output logic [SUM_W-1:0]        sum_o
);

    // Each lane is sign-extended to the full sum width before adding, so the
    // running total never overflows for any combination of lane values.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_o = sum_o + {{(SUM_W-PROD_W){mult_i[i*PROD_W+PROD_W-1]}},
                             mult_i[i*PROD_W +: PROD_W]};
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - pops product groups, reduces them and accumulates one row
//
// Ports:
//   clk             in   1             clock, rising edge
//   rst             in   1             synchronous active-high reset
//   start           in   1             begin a row (honoured only when idle)
//   row_len         in   LEN_W         groups in the row, sampled with start
//   mult            in   LANES*PROD_W  head word of each lane's mult FIFO
//   mult_fifo_empty in   LANES         per-lane FIFO empty flag
//   mult_fifo_read  out  LANES         per-lane pop strobe, always all-or-none
//   sum             out  ACC_W         accumulated row result
//   sum_valid       out  1             sum holds a completed row
//   sum_ready       in   1             consumer accepts sum
//   busy            out  1             row in progress or result pending
module mult_accumulator
    import sparse_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        row_len,
    input  logic [LANES*PROD_W-1:0] mult,
    input  logic [LANES-1:0]        mult_fifo_empty,
    output logic [LANES-1:0]        mult_fifo_read,
    output logic [ACC_W-1:0]        sum,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    busy
);

    localparam int SUM_W = tree_w(LANES, PROD_W);

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued_q;
    logic [LEN_W-1:0]   done_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   sum_q;
    logic               sum_valid_q;
    logic [SUM_W-1:0]   tree_sum;
    logic [SUM_W-1:0]   s1_sum_q;
    logic               s1_v_q;
    logic               fire;

    lane_adder_tree #(
        .LANES  (LANES),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_tree (
        .mult_i (mult),
        .sum_o  (tree_sum)
    );

    // A group is consumed only when every lane has data, so lanes never
    // drift out of step; issued_q caps pops at the row length.
    assign fire           = (state_q == ST_ACCUM) && !(|mult_fifo_empty) && (issued_q < len_q);
    assign mult_fifo_read = {LANES{fire}};

    // Accumulation wraps modulo 2^ACC_W.
    assign acc_d = acc_q + {{(ACC_W-SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q};

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            s1_sum_q    <= '0;
            s1_v_q      <= 1'b0;
        end else begin
            // Stage 1: register the reduced group.
            s1_v_q <= fire;
            if (fire) begin
                s1_sum_q <= tree_sum;
                issued_q <= issued_q + LEN_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_ACCUM;
                        len_q    <= row_len;
                        issued_q <= '0;
                        done_q   <= '0;
                        acc_q    <= '0;
                    end
                end
                ST_ACCUM: begin
                    // Stage 2: fold the registered group into the row total.
                    if (s1_v_q) begin
                        acc_q  <= acc_d;
                        done_q <= done_q + LEN_W'(1);
                    end
                    // done_q only reaches len_q once the last group has
                    // left stage 2, so acc_q is final here.
                    if (done_q == len_q) begin
                        state_q     <= ST_DRAIN;
                        sum_q       <= acc_q;
                        sum_valid_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (sum_ready) begin
                        state_q     <= ST_IDLE;
                        sum_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sum_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - scoreboard bench for mult_accumulator
module tb_mult_accumulator;

    localparam int L  = 4;
    localparam int PW = 16;
    localparam int AW = 32;
    localparam int LW = 16;

    typedef struct {
        logic [AW-1:0] sum;
        int            len;
        int            st;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LW-1:0]     row_len = '0;
    logic [L*PW-1:0]   mult = '0;
    logic [L-1:0]      mult_fifo_empty = '1;
    logic [L-1:0]      mult_fifo_read;
    logic [AW-1:0]     sum;
    logic              sum_valid;
    logic              sum_ready = 1'b1;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_pop = 0;
    int row_pops = 0;
    bit mon_en = 1'b0;
    bit hold = 1'b0;
    bit rand_ready = 1'b0;
    bit rand_stall = 1'b0;
    bit sv_prev = 1'b0;
    logic [L-1:0]    force_stall = '0;
    logic [L-1:0]    stall = '0;
    logic [L-1:0]    rd_s = '0;
    logic [L*PW-1:0] grp_q[$];
    logic [L*PW-1:0] stage[$];
    exp_t            exp_q[$];

    always #5 clk = ~clk;

    mult_accumulator dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .row_len         (row_len),
        .mult            (mult),
        .mult_fifo_empty (mult_fifo_empty),
        .mult_fifo_read  (mult_fifo_read),
        .sum             (sum),
        .sum_valid       (sum_valid),
        .sum_ready       (sum_ready),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [L*PW-1:0] grp(input int a3, input int a2, input int a1, input int a0);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    // FWFT FIFO model: one shared queue since all lanes pop together;
    // a lane can be made to look empty through stall.
    function automatic void drive_fifo();
        mult = (grp_q.size() > 0) ? grp_q[0] : '0;
        for (int i = 0; i < L; i++)
            mult_fifo_empty[i] = (grp_q.size() == 0) || stall[i];
    endfunction

    // Monitor: pop rules, latency and scoreboard comparison on handshake.
    always @(negedge clk) begin
        rd_s = mult_fifo_read;
        if (mon_en) begin
            if (mult_fifo_read != '0) begin
                chk("pop_lockstep", mult_fifo_read, {L{1'b1}});
                chk("pop_while_empty", mult_fifo_empty, '0);
                last_pop = cyc;
                row_pops++;
            end
            if (sum_valid) begin
                if (exp_q.size() == 0) begin
                    if (!sv_prev) chk("unexpected_sum_valid", sum_valid, 0);
                end else begin
                    if (!sv_prev) begin
                        if (exp_q[0].len == 0) chk("latency_len0", cyc - exp_q[0].st, 2);
                        else                   chk("latency_last_pop", cyc - last_pop, 3);
                    end
                    chk("sum", sum, exp_q[0].sum);
                    if (sum_ready) begin
                        chk("pop_count", row_pops, exp_q[0].len);
                        void'(exp_q.pop_front());
                        row_pops = 0;
                    end
                end
            end
            sv_prev = sum_valid;
        end
    end

    // FIFO/consumer driver: apply the pop seen last cycle, then new flags.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (mon_en && rd_s == {L{1'b1}} && grp_q.size() > 0) void'(grp_q.pop_front());
        stall = force_stall;
        if (rand_stall && $urandom_range(0, 3) == 0) stall = stall | L'($urandom);
        if (hold) sum_ready = 1'b0;
        else      sum_ready = rand_ready ? 1'($urandom) : 1'b1;
        drive_fifo();
    end

    // Issues one row from stage[]; the first len groups form the expected sum,
    // the rest stay in the FIFOs to tempt an overrun.
    task automatic run_row(input int len, input int stall_at, input int hold_cyc);
        longint acc = 0;
        exp_t e;
        int n = 0;
        int held = 0;
        int rel_n = -1;
        bit fin = 1'b0;
        for (int g = 0; g < len; g++)
            for (int l = 0; l < L; l++)
                acc += longint'($signed(stage[g][l*PW +: PW]));
        @(posedge clk); #2;
        foreach (stage[i]) grp_q.push_back(stage[i]);
        stage.delete();
        hold = (hold_cyc > 0);
        if (hold) sum_ready = 1'b0;
        drive_fifo();
        e.sum = acc[AW-1:0];
        e.len = len;
        e.st  = cyc;
        exp_q.push_back(e);
        start   = 1'b1;
        row_len = LW'(len);
        while (!fin) begin
            @(posedge clk); #2;
            n++;
            start = 1'b0;
            if (stall_at > 0) begin
                if (n == stall_at)     force_stall = 4'b0100;
                if (n == stall_at + 3) force_stall = '0;
                stall = force_stall;
                drive_fifo();
            end
            if (hold && sum_valid) begin
                held++;
                if (held == 5) begin
                    start   = 1'b1;
                    row_len = 7;
                end
                if (held == hold_cyc) begin
                    hold      = 1'b0;
                    sum_ready = 1'b1;
                    start     = 1'b1;
                    row_len   = 3;
                    rel_n     = n;
                end
            end
            if (!busy && n > 1) begin
                fin = 1'b1;
            end else if (n > len * 8 + 200) begin
                chk("row_timeout_busy", busy, 0);
                hold = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end
        end
        start = 1'b0;
        if (hold_cyc > 0) chk("idle_after_ready", n, rel_n + 1);
        force_stall = '0;
        stall       = '0;
        grp_q.delete();
        drive_fifo();
    endtask

    initial begin
        grp_q.push_back(grp(1, 2, 3, 4));
        drive_fifo();
        @(posedge clk); #2;
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_read", mult_fifo_read, 0);
            chk("rst_sum_valid", sum_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_busy", busy, 0);
            @(posedge clk); #2;
        end
        rst = 1'b0;
        grp_q.delete();
        drive_fifo();

        // single group, one spare group left behind
        stage.push_back(grp(0, 36, -112, 75));
        stage.push_back(grp(5, 5, 5, 5));
        run_row(1, 0, 0);

        // two groups, two spare
        stage.push_back(grp(0, 36, -112, 75));
        stage.push_back(grp(0, 360, -192, 500));
        stage.push_back(grp(9, 9, 9, 9));
        stage.push_back(grp(-9, 9, -9, 9));
        run_row(2, 0, 0);

        // lane 2 stalls three cycles mid-row
        for (int g = 0; g < 6; g++) stage.push_back(grp(1, 1, 1, 1));
        run_row(4, 1, 0);

        // backpressure with starts ignored while busy
        for (int g = 0; g < 6; g++) stage.push_back({$urandom, $urandom});
        run_row(2, 0, 10);

        // empty row with data sitting in the FIFOs
        for (int g = 0; g < 3; g++) stage.push_back(grp(7, 7, 7, 7));
        run_row(0, 0, 0);

        // drive the accumulator through 0x7FFFFFFF and wrap by one
        for (int g = 0; g < 16384; g++) stage.push_back(grp(32767, 32767, 32767, 32767));
        stage.push_back(grp(0, 1, 32767, 32767));
        stage.push_back(grp(0, 0, 0, 1));
        run_row(16386, 0, 0);

        // random rows with random stalls and consumer backpressure
        rand_stall = 1'b1;
        rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int len;
            int extra;
            len   = $urandom_range(0, 12);
            extra = $urandom_range(0, 3);
            for (int g = 0; g < len + extra; g++) stage.push_back({$urandom, $urandom});
            run_row(len, 0, 0);
        end
        rand_stall = 1'b0;
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
